// File: rtl/tetris_move_sched_pkg.sv
// tetris_move_sched_pkg: move encoding shared with the game FSM and the scheduler state type
package tetris_move_sched_pkg;
  typedef enum logic [2:0] {
    MV_RIGHT = 3'd0,
    MV_LEFT  = 3'd1,
    MV_ROR   = 3'd2,
    MV_ROL   = 3'd3,
    MV_DOWN  = 3'd4,
    MV_NONE  = 3'd5
  } move_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_BUSY} sched_state_t;
  localparam int N_REQ = 5;
  // pending vector is indexed by move code, so the lowest set bit wins
  function automatic move_t pick_move(input logic [N_REQ-1:0] pend);
    return pend[0] ? MV_RIGHT :
           pend[1] ? MV_LEFT  :
           pend[2] ? MV_ROR   :
           pend[3] ? MV_ROL   :
           pend[4] ? MV_DOWN  : MV_NONE;
  endfunction
endpackage

// File: rtl/tetris_move_sched_gravity_timer.sv
// tetris_move_sched_gravity_timer: gravity counter with soft-drop period select and tick pulse
module tetris_move_sched_gravity_timer #(
  parameter int GRAVITY_TICKS = 12_500_000,
  parameter int FAST_TICKS    = 1_250_000,
  parameter int CNT_W         = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clr,
  input  logic i_fast,
  output logic o_wrap,
  output logic o_tick
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic             r_tick;
  assign w_last = i_fast ? CNT_W'(FAST_TICKS - 1) : CNT_W'(GRAVITY_TICKS - 1);
  // >= lets a mid-count switch to the fast period wrap immediately
  assign o_wrap = i_run && (r_cnt >= w_last);
  assign o_tick = r_tick;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= o_wrap;
      if (i_run) r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/tetris_move_sched.sv
// tetris_move_sched: merges button edges and gravity into one move stream over valid/ready + done
module tetris_move_sched
  import tetris_move_sched_pkg::*;
#(
  parameter int GRAVITY_TICKS = 12_500_000,
  parameter int FAST_TICKS    = 1_250_000,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       right,
  input  logic       left,
  input  logic       rr,
  input  logic       rl,
  input  logic       soft_drop,
  input  logic       move_ready,
  input  logic       move_done,
  output logic       move_valid,
  output logic [2:0] move,
  output logic       busy,
  output logic       tick
);
  sched_state_t     r_state;
  move_t            r_move;
  logic             r_valid;
  logic             r_busy;
  logic [3:0]       r_hist;
  logic [N_REQ-1:0] r_pend;
  logic [3:0]       w_btn;
  logic [N_REQ-1:0] w_set;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_pend_nxt;
  logic             w_wrap;
  logic             w_run;
  logic             w_stop;
  assign w_btn      = {rl, rr, left, right};
  assign w_set      = {w_wrap, w_btn & ~r_hist};
  assign w_clr      = (r_state == S_ISSUE && move_ready) ? N_REQ'(1) << r_move : '0;
  // clear before set: an edge arriving with the accept re-arms the request
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;
  assign w_run      = en && (r_state != S_IDLE);
  assign w_stop     = !en;
  assign move_valid = r_valid;
  assign move       = r_move;
  assign busy       = r_busy;
  tetris_move_sched_gravity_timer #(
    .GRAVITY_TICKS(GRAVITY_TICKS),
    .FAST_TICKS   (FAST_TICKS),
    .CNT_W        (CNT_W)
  ) u_gravity (
    .clk   (clk),
    .rst   (rst),
    .i_run (w_run),
    .i_clr (w_stop),
    .i_fast(soft_drop),
    .o_wrap(w_wrap),
    .o_tick(tick)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_move  <= MV_NONE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_pend  <= '0;
      r_hist  <= '0;
    end else begin
      r_hist <= w_btn;
      if (!en) begin
        r_state <= S_IDLE;
        r_move  <= MV_NONE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_pend  <= '0;
      end else begin
        r_pend <= w_pend_nxt;
        case (r_state)
          S_IDLE: r_state <= S_WAIT;
          S_WAIT: if (|r_pend) begin
            r_move  <= pick_move(r_pend);
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
          S_ISSUE: if (move_ready) begin
            r_move  <= MV_NONE;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
          S_BUSY: if (move_done) begin
            r_busy  <= 1'b0;
            r_state <= S_WAIT;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tetris_move_sched.sv
// tb_tetris_move_sched: randomized + directed scoreboard bench against a behavioural move model
module tb_tetris_move_sched;
  localparam int GRAV = 8;
  localparam int FAST = 2;
  logic clk = 0, rst = 1, en = 0;
  logic right = 0, left = 0, rr = 0, rl = 0, soft_drop = 0, move_ready = 0, move_done = 0;
  logic move_valid, busy, tick;
  logic [2:0] move;
  int total = 0, bad = 0;

  tetris_move_sched #(.GRAVITY_TICKS(GRAV), .FAST_TICKS(FAST), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .right(right), .left(left), .rr(rr), .rl(rl),
    .soft_drop(soft_drop), .move_ready(move_ready), .move_done(move_done),
    .move_valid(move_valid), .move(move), .busy(busy), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 waiting, 2 offering, 3 in flight.
  // want[k] holds an outstanding request for move code k.
  int  m_phase = 0, m_cnt = 0, m_mv = 5;
  bit  want [5];
  bit  m_prev [4];
  bit  m_valid = 0, m_busy = 0, m_tick = 0;
  int  exp_q [$];
  bit  btn [4];
  bit  fresh [4];
  bit  wrap, acc;
  int  per;

  always @(posedge clk) begin
    btn = '{right, left, rr, rl};
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_mv = 5; m_valid = 0; m_busy = 0; m_tick = 0;
      foreach (want[k]) want[k] = 0;
      foreach (m_prev[k]) m_prev[k] = 0;
      exp_q.delete();
    end else begin
      foreach (btn[k]) begin fresh[k] = btn[k] && !m_prev[k]; m_prev[k] = btn[k]; end
      if (!en) begin
        m_phase = 0; m_cnt = 0; m_mv = 5; m_valid = 0; m_busy = 0; m_tick = 0;
        foreach (want[k]) want[k] = 0;
      end else begin
        per    = soft_drop ? FAST : GRAV;
        wrap   = (m_phase != 0) && (m_cnt >= per - 1);
        m_tick = wrap;
        if (m_phase != 0) m_cnt = wrap ? 0 : m_cnt + 1;
        acc = (m_phase == 2) && move_ready;
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
          for (int k = 0; k < 5; k++) if (want[k] && m_phase == 1) begin
            m_mv = k; m_phase = 2; m_valid = 1; exp_q.push_back(k);
          end
        end else if (m_phase == 2) begin
          if (move_ready) begin m_valid = 0; m_busy = 1; m_phase = 3; end
        end else if (move_done) begin
          m_busy = 0; m_phase = 1;
        end
        if (acc) want[m_mv] = 0;
        foreach (fresh[k]) if (fresh[k]) want[k] = 1;
        if (wrap) want[4] = 1;
      end
    end
  end

  bit last_v = 0;
  always @(negedge clk) begin
    if (rst) last_v = 0;
    else begin
      chk("valid", move_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("tick", tick, m_tick);
      if (!move_valid) chk("move_idle", move, 5);
      else if (!last_v) begin
        if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
        else chk("move", move, exp_q.pop_front());
      end
      last_v = move_valid;
    end
  end

  int  bcnt = 0;
  bit  auto_done = 1, rnd_done = 0, sv = 0;
  int  seen [$];

  task automatic step();
    @(posedge clk); #1;
    if (rst) sv = 0;
    else begin
      if (move_valid && !sv) seen.push_back(int'(move));
      sv = move_valid;
    end
    bcnt = busy ? bcnt + 1 : 0;
    if (rnd_done) move_done = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
    else move_done = auto_done && busy && (bcnt == 2);
  endtask

  task automatic wait_for(input string name, input int which);
    int n = 0;
    while (!(which == 0 ? move_valid : which == 1 ? busy : tick) && n < 60) begin step(); n++; end
    chk({name, "_timeout"}, int'(n < 60), 1);
  endtask

  function automatic int at(input int i);
    return i < seen.size() ? seen[i] : -1;
  endfunction

  initial begin
    step(); step();
    chk("rst_valid", move_valid, 0);
    chk("rst_move", move, 5);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    rst = 0; en = 1; move_ready = 1;
    begin : t1
      int last = -1, vcnt = 0;
      for (int c = 0; c < 40; c++) begin
        step();
        if (move_valid) vcnt++;
        if (tick) begin
          if (last >= 0) chk("t1_tick_period", c - last, GRAV);
          last = c;
        end
      end
      chk("t1_downs", seen.size(), 4);
      chk("t1_valid_cycles", vcnt, 4);
      foreach (seen[i]) chk("t1_down_kind", seen[i], 4);
    end
    seen.delete();
    right = 1; rr = 1; step(); right = 0; rr = 0;
    repeat (14) step();
    chk("t2_first", at(0), 0);
    chk("t2_second", at(1), 2);
    seen.delete();
    left = 1; repeat (20) step(); left = 0; repeat (6) step();
    begin : t3
      int n = 0;
      foreach (seen[i]) if (seen[i] == 1) n++;
      chk("t3_left_once", n, 1);
    end
    repeat (10) step();
    wait_for("t4_tick", 2);
    repeat (5) step();
    seen.delete();
    move_ready = 0; right = 1; step(); right = 0;
    wait_for("t4_valid", 0);
    begin : t4
      int tk = 0;
      for (int c = 0; c < 9; c++) begin
        step();
        chk("t4_hold_valid", move_valid, 1);
        chk("t4_hold_move", move, 0);
        if (tick) tk++;
      end
      chk("t4_tick_seen", int'(tk > 0), 1);
    end
    move_ready = 1; repeat (8) step();
    chk("t4_first", at(0), 0);
    chk("t4_then_down", at(1), 4);
    repeat (10) step();
    wait_for("t5_tick", 2);
    repeat (5) step();
    soft_drop = 1;
    for (int c = 0; c < 5; c++) begin step(); chk("t5_fast_tick", tick, int'(c % 2 == 0)); end
    soft_drop = 0;
    repeat (12) step();
    auto_done = 0;
    wait_for("t6_busy", 1);
    en = 0; step();
    chk("t6_busy_off", busy, 0);
    chk("t6_move_none", move, 5);
    chk("t6_valid_off", move_valid, 0);
    step(); en = 1; auto_done = 1;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk("t6_restart_tick", tick, int'(c == 9));
      chk("t6_no_stale", move_valid, 0);
    end
    repeat (10) step();
    move_ready = 0; left = 1; step(); left = 0;
    wait_for("t7_valid", 0);
    @(negedge clk); #1; rst = 1; #1;
    chk("t7_rst_valid", move_valid, 0);
    chk("t7_rst_move", move, 5);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_tick", tick, 0);
    step(); step(); rst = 0; move_ready = 1;
    rnd_done = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) right = ~right;
      if ($urandom_range(0, 5) == 0) left = ~left;
      if ($urandom_range(0, 5) == 0) rr = ~rr;
      if ($urandom_range(0, 5) == 0) rl = ~rl;
      if ($urandom_range(0, 39) == 0) soft_drop = ~soft_drop;
      move_ready = $urandom_range(0, 3) != 0;
      if (en && $urandom_range(0, 149) == 0) en = 0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1;
      step();
    end
    @(negedge clk); #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tetris_move_sched.md
Name: tetris_move_sched

Overview:
Schedules the piece-movement requests that drive the Tetris game FSM. Merges four button inputs (right, left, rotate-right, rotate-left) with a gravity timer into a single stream of move_t commands. Issues one command at a time over a valid/ready + done handshake, so the frame-tracking datapath sees one move per tracked step. Sits between the input synchronizers and the game FSM; the FSM consumes move/move_valid in place of its own button decode.

Parameters:
GRAVITY_TICKS, 12_500_000, clock cycles between gravity DOWN requests at normal speed (must be >= 2)
FAST_TICKS, 1_250_000, gravity period while soft_drop is held (must be >= 2 and <= GRAVITY_TICKS)
CNT_W, 24, gravity counter width; must hold GRAVITY_TICKS-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  game active; low = scheduler idle, pending state cleared
right  in  1  synchronized level, move right
left  in  1  synchronized level, move left
rr  in  1  synchronized level, rotate right
rl  in  1  synchronized level, rotate left
soft_drop  in  1  level; selects FAST_TICKS gravity period
move_ready  in  1  FSM can accept a move this cycle
move_done  in  1  FSM finished applying the accepted move (1-cycle pulse)
move_valid  out  1  move holds a valid command
move  out  3  move_t: RIGHT=0, LEFT=1, ROR=2, ROL=3, DOWN=4, NONE=5
busy  out  1  a move is accepted and not yet done
tick  out  1  1-cycle pulse when gravity counter wraps

Behaviour:
- Reset: move_valid=0, move=NONE, busy=0, tick=0, state=IDLE, counter=0, all pending bits=0, button history regs=0.
- Button capture: rising edge of each of right/left/rr/rl (vs. previous-cycle sample) sets its pending bit; held buttons do not repeat. Pending bits saturate at 1.
- Gravity: while en=1 counter increments every cycle in every non-IDLE state, including while busy. Period P = soft_drop ? FAST_TICKS : GRAVITY_TICKS. When counter >= P-1: counter<=0, tick=1, pend_down<=1. The >= compare makes a mid-count switch to soft_drop wrap on the next cycle.
- States:
- IDLE: outputs inactive. en=1 -> WAIT next cycle.
- WAIT: if any pending bit, latch the highest-priority move into the move register, set move_valid -> ISSUE. Priority is RIGHT > LEFT > ROR > ROL > DOWN.
- ISSUE: move_valid=1 and move held stable. When move_ready=1, clear that move's pending bit (a new edge in the same cycle keeps it set), move_valid<=0, busy<=1 -> BUSY.
- BUSY: move=NONE. On move_done: busy<=0 -> WAIT. move_done outside BUSY is ignored.
- Latency: a pending request reaches move_valid 1 cycle after WAIT sees it. Edge to move_valid is 2 cycles when idle in WAIT.
- Priority is re-evaluated only in WAIT; a higher-priority press during ISSUE does not preempt the held move.
- en=0 in any state: next cycle IDLE, move_valid=0, busy=0, move=NONE, pending bits and counter cleared. The FSM treats this as an abort.
- Simultaneous move_ready and en=0: en wins; no handshake completes.
- move_ready while not in ISSUE: ignored.

Decomposition:
- tetrispkg: move_t (shared with the game FSM and tracker), sched_state_t {IDLE, WAIT, ISSUE, BUSY}.
- One sub-module, gravity_timer (counter, period select, tick); edge detect, pending bits and the FSM stay in tetris_move_sched.

Test Plan:
- Run with GRAVITY_TICKS=8, FAST_TICKS=2, en=1, no buttons, move_ready=1, move_done 2 cycles after accept -> tick every 8 cycles; each tick yields move=DOWN with move_valid for 1 cycle.
- Pulse right and rr in the same cycle -> RIGHT issued first; after move_done, ROR issued; then pending bits are 0.
- Hold left high for 20 cycles -> exactly one LEFT issued.
- Hold move_ready=0 for 5 cycles with RIGHT valid, while a gravity tick occurs -> move stays RIGHT and valid for all 5 cycles; DOWN is issued after RIGHT's move_done.
- Assert soft_drop at counter=5 (GRAVITY_TICKS=8) -> tick on the next cycle, then every 2 cycles.
- Drop en while in BUSY -> next cycle busy=0, move=NONE, state IDLE; re-enable -> counter restarts from 0 and there is no stale pending move. Then assert rst mid-ISSUE -> all outputs take their reset values immediately.
